// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder.
// Takes a big-endian 32-bit word stream. After the final word it appends the
// 0x80 marker, zero fill and the 64-bit bit length. The result is a sequence of
// 16-word blocks for a SHA-1 core. A single output register gives latency 1.
// Block and message framing flags travel with each word in that register.
module sha1_msg_padder (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        active,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [1:0]  in_bytes,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_first,
    output logic        out_blk_end,
    output logic        out_msg_end
);

    typedef enum logic [2:0] {
        ST_DATA   = 3'd0,
        ST_MARK   = 3'd1,
        ST_ZERO   = 3'd2,
        ST_LEN_HI = 3'd3,
        ST_LEN_LO = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  w_reg, w_next;           // block index of the next word produced
    logic [63:0] cnt_reg, cnt_next;       // message length in bytes
    logic        ov_reg, ov_next;
    logic [31:0] od_reg, od_next;
    logic        of_reg, of_next;
    logic        ob_reg, ob_next;
    logic        om_reg, om_next;

    logic        can_load;
    logic        in_take;
    logic        do_load;
    logic [31:0] load_data;
    logic        load_msg_end;
    logic [63:0] len_bits;
    logic [63:0] add_bytes;
    logic [31:0] last_word;

    // The output register may be refilled when it is empty or being drained this cycle.
    assign can_load  = active & (~ov_reg | out_ready);
    assign in_ready  = wb_rst_ni & active & (state_reg == ST_DATA) & (~ov_reg | out_ready);
    assign in_take   = in_valid & in_ready;
    assign len_bits  = {cnt_reg[60:0], 3'b000};
    assign add_bytes = (in_last && in_bytes != 2'd0) ? {62'd0, in_bytes} : 64'd4;

    assign out_valid   = ov_reg & active;
    assign out_data    = od_reg;
    assign out_first   = of_reg;
    assign out_blk_end = ob_reg;
    assign out_msg_end = om_reg;

    // Keep the valid bytes of a partial final word and place the 0x80 marker right after them.
    always_comb begin
        last_word = in_data;
        case (in_bytes)
            2'd1:    last_word = {in_data[31:24], 8'h80, 16'h0000};
            2'd2:    last_word = {in_data[31:16], 8'h80, 8'h00};
            2'd3:    last_word = {in_data[31:8], 8'h80};
            default: last_word = in_data;
        endcase
    end

    // Compute the next state and the word to load into the output register.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        do_load      = 1'b0;
        load_data    = 32'h0000_0000;
        load_msg_end = 1'b0;

        case (state_reg)
            ST_DATA: begin
                if (in_take) begin
                    do_load   = 1'b1;
                    load_data = in_last ? last_word : in_data;
                    cnt_next  = cnt_reg + add_bytes;
                    if (in_last)
                        state_next = (in_bytes == 2'd0) ? ST_MARK : ST_ZERO;
                end
            end
            ST_MARK: begin
                if (can_load) begin
                    do_load    = 1'b1;
                    load_data  = 32'h8000_0000;
                    state_next = ST_ZERO;
                end
            end
            ST_ZERO: begin
                // Slot 14 is reserved for the length. Hand over to LEN_HI without emitting a word.
                if (w_reg == 4'd14) begin
                    if (active)
                        state_next = ST_LEN_HI;
                end else if (can_load) begin
                    do_load = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (can_load) begin
                    do_load    = 1'b1;
                    load_data  = len_bits[63:32];
                    state_next = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (can_load) begin
                    do_load      = 1'b1;
                    load_data    = len_bits[31:0];
                    load_msg_end = 1'b1;
                    cnt_next     = 64'd0;
                    state_next   = ST_DATA;
                end
            end
            default: state_next = ST_DATA;
        endcase
    end

    // Update the output register. A stalled word is held until the core accepts it.
    always_comb begin
        w_next  = w_reg;
        ov_next = ov_reg;
        od_next = od_reg;
        of_next = of_reg;
        ob_next = ob_reg;
        om_next = om_reg;
        if (active && ov_reg && out_ready)
            ov_next = 1'b0;
        if (do_load) begin
            ov_next = 1'b1;
            od_next = load_data;
            of_next = (w_reg == 4'd0);
            ob_next = (w_reg == 4'd15);
            om_next = load_msg_end;
            w_next  = w_reg + 4'd1;   // wraps 15 -> 0
        end
    end

    // State, counter and output register. Reset discards any partial message.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_reg <= ST_DATA;
            w_reg     <= 4'd0;
            cnt_reg   <= 64'd0;
            ov_reg    <= 1'b0;
            od_reg    <= 32'h0000_0000;
            of_reg    <= 1'b0;
            ob_reg    <= 1'b0;
            om_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            w_reg     <= w_next;
            cnt_reg   <= cnt_next;
            ov_reg    <= ov_next;
            od_reg    <= od_next;
            of_reg    <= of_next;
            ob_reg    <= ob_next;
            om_reg    <= om_next;
        end
    end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Scoreboard bench for sha1_msg_padder.
// The stimulus pushes expected padded words into a queue. A monitor pops and
// compares them on every output transfer. The monitor also checks that held
// words stay stable and that the interface is idle while active is low.
module tb_sha1_msg_padder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        active;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [1:0]  in_bytes;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_first;
    logic        out_blk_end;
    logic        out_msg_end;

    typedef struct packed {
        logic [31:0] d;
        logic        f;
        logic        b;
        logic        m;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_pop = 0;
    int   ready_mode = 0;     // 0: always ready, 1: random stalls, 2: never ready
    logic held = 1'b0;
    exp_t held_v;

    sha1_msg_padder dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .active      (active),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_bytes    (in_bytes),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_first   (out_first),
        .out_blk_end (out_blk_end),
        .out_msg_end (out_msg_end)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: sample mid-cycle; a valid&ready seen here transfers at the next rising edge.
    always @(negedge clk) begin
        exp_t act;
        exp_t e;
        act = '{d: out_data, f: out_first, b: out_blk_end, m: out_msg_end};
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (!active) begin
                n_vec++;
                if (out_valid || in_ready) begin
                    n_err++;
                    $display("FAIL gap_idle: out_valid=%0b in_ready=%0b, required 0/0", out_valid, in_ready);
                end
            end
            if (held && out_valid) begin
                n_vec++;
                if (act !== held_v) begin
                    n_err++;
                    $display("FAIL stall_stable: got %h/%b%b%b, required %h/%b%b%b",
                             act.d, act.f, act.b, act.m, held_v.d, held_v.f, held_v.b, held_v.m);
                end
                held = 1'b0;
            end
            if (out_valid && out_ready) begin
                n_vec++;
                n_pop++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_word: got %h, required none", act.d);
                end else begin
                    e = q.pop_front();
                    if (act !== e) begin
                        n_err++;
                        $display("FAIL word%0d: got %h f%b b%b m%b, required %h f%b b%b m%b",
                                 n_pop - 1, act.d, act.f, act.b, act.m, e.d, e.f, e.b, e.m);
                    end
                end
            end else if (out_valid && !out_ready) begin
                held   = 1'b1;
                held_v = act;
            end
        end
    end

    // Message byte i is i+1; bytes past the end of the message are 0xEE junk.
    function automatic logic [31:0] msg_word(input int nbytes, input int j);
        logic [31:0] d;
        for (int k = 0; k < 4; k++) begin
            d[31-8*k -: 8] = (4*j + k < nbytes) ? 8'(4*j + k + 1) : 8'hEE;
        end
        return d;
    endfunction

    // Byte-level padding reference: message, 0x80, zeros, then the 64-bit big-endian bit count.
    task automatic push_model(input int nbytes);
        logic [7:0]  b [0:255];
        logic [63:0] len;
        int          total;
        total = ((nbytes + 8) / 64 + 1) * 64;
        for (int i = 0; i < 256; i++) b[i] = 8'h00;
        for (int i = 0; i < nbytes; i++) b[i] = 8'(i + 1);
        b[nbytes] = 8'h80;
        len = 64'(nbytes) * 64'd8;
        for (int k = 0; k < 8; k++) b[total-8+k] = len[63-8*k -: 8];
        for (int j = 0; j < total / 4; j++) begin
            q.push_back('{d: {b[4*j], b[4*j+1], b[4*j+2], b[4*j+3]},
                          f: (j % 16 == 0), b: (j % 16 == 15), m: (j == total / 4 - 1)});
        end
    endtask

    // Offer one word. Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] d, input logic l, input logic [1:0] nb);
        int t = 0;
        in_data  = d;
        in_last  = l;
        in_bytes = nb;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL in_accept: in_ready=0 after %0d cycles, required 1", t);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_msg(input int nbytes);
        int nw;
        nw = (nbytes + 3) / 4;
        for (int j = 0; j < nw; j++) begin
            send(msg_word(nbytes, j), (j == nw - 1), 2'(nbytes % 4));
        end
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d words outstanding, required 0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_abc();
        q.push_back('{d: 32'h6162_6380, f: 1'b1, b: 1'b0, m: 1'b0});
        for (int i = 1; i < 15; i++)
            q.push_back('{d: 32'h0000_0000, f: 1'b0, b: 1'b0, m: 1'b0});
        q.push_back('{d: 32'h0000_0018, f: 1'b0, b: 1'b1, m: 1'b1});
    endtask

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    initial begin
        int base;
        int t;
        rst_n     = 1'b0;
        active    = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_last   = 1'b0;
        in_bytes  = 2'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check1("rst_out_valid", 32'(out_valid), 32'd0);
        check1("rst_out_data", out_data, 32'd0);
        check1("rst_flags", {29'd0, out_first, out_blk_end, out_msg_end}, 32'd0);
        check1("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // "abc", no stalls
        push_abc();
        send(32'h6162_6300, 1'b1, 2'd3);
        drain();

        // Length boundaries: one block, extra block, marker-only word, 1/2-byte tails
        push_model(55); send_msg(55); drain();
        push_model(56); send_msg(56); drain();
        push_model(1);  send_msg(1);  drain();
        push_model(62); send_msg(62); drain();
        push_model(64); send_msg(64); drain();

        // "abc" under random output stalls
        ready_mode = 1;
        push_abc();
        send(32'h6162_6300, 1'b1, 2'd3);
        drain();
        push_model(57); send_msg(57); drain();
        ready_mode = 0;

        // Reset with a stalled fifth word pending
        for (int j = 0; j < 4; j++) begin
            q.push_back('{d: msg_word(80, j), f: (j == 0), b: 1'b0, m: 1'b0});
            send(msg_word(80, j), 1'b0, 2'd0);
        end
        ready_mode = 2;
        send(msg_word(80, 4), 1'b0, 2'd0);
        repeat (3) @(negedge clk);
        check1("pre_rst_valid", 32'(out_valid), 32'd1);
        check1("pre_rst_data", out_data, msg_word(80, 4));
        check1("pre_rst_drained", 32'(q.size()), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check1("async_rst_valid", 32'(out_valid), 32'd0);
        check1("async_rst_data", out_data, 32'd0);
        check1("async_rst_in_ready", 32'(in_ready), 32'd0);
        q.delete();
        ready_mode = 0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_abc();
        send(32'h6162_6300, 1'b1, 2'd3);
        drain();

        // active low for 10 cycles during zero fill
        base = n_pop;
        push_abc();
        send(32'h6162_6300, 1'b1, 2'd3);
        t = 0;
        while (n_pop < base + 5 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        active = 1'b0;
        base = n_pop;
        repeat (10) @(posedge clk);
        check1("gap_no_transfer", 32'(n_pop), 32'(base));
        #1;
        active = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sha1_msg_padder.md
SHA1_MSG_PADDER -- requirements
Module: sha1_msg_padder

Interface
REQ-001 SHALL have ports: wb_clk_i  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: wb_rst_ni  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: active  in  1  enable; low forces in_ready=0 and out_valid=0 and holds state.
REQ-004 SHALL have ports: in_valid  in  1  upstream message word valid.
REQ-005 SHALL have ports: in_ready  out  1  padder accepts word this cycle.
REQ-006 SHALL have ports: in_data  in  32  message word, big-endian, byte 0 in [31:24].
REQ-007 SHALL have ports: in_last  in  1  word is final word of message.
REQ-008 SHALL have ports: in_bytes  in  2  valid bytes in last word, 1..3, 0 meaning 4; ignored when in_last=0.
REQ-009 SHALL have ports: out_valid  out  1  padded word valid toward SHA-1 core.
REQ-010 SHALL have ports: out_ready  in  1  core accepts word.
REQ-011 SHALL have ports: out_data  out  32  padded block word.
REQ-012 SHALL have ports: out_first  out  1  word is index 0 of a 512-bit block.
REQ-013 SHALL have ports: out_blk_end  out  1  word is index 15 of a block.
REQ-014 SHALL have ports: out_msg_end  out  1  word is index 15 of the final block of the message.

Function
REQ-015 SHALL transfer on in_valid&in_ready and on out_valid&out_ready only; out_data/out_* flags SHALL be held stable while out_valid=1 and out_ready=0.
REQ-016 SHALL use a single output register: in_ready = active & state==DATA & (!out_valid | out_ready); accepted word appears on out_data next cycle (latency 1).
REQ-017 SHALL keep 4-bit word index w (0..15) of the next emitted word, incremented per output transfer, wrapping 15->0; out_first = (w==0), out_blk_end = (w==15).
REQ-018 SHALL keep 64-bit byte counter incremented by 4 per non-last input word and by in_bytes (0->4) on last; length field = counter<<3, modulo 2^64.
REQ-019 SHALL implement states DATA, MARK, ZERO, LEN_HI, LEN_LO.
REQ-020 DATA, non-last word: emit in_data unchanged; stay DATA.
REQ-021 DATA, last word with in_bytes=1/2/3: emit valid bytes, 0x80 in next byte, zeros below; go ZERO.
REQ-022 DATA, last word with in_bytes=0: emit in_data; go MARK.
REQ-023 MARK: emit 0x80000000 without input; go ZERO.
REQ-024 ZERO: emit 0x00000000 while w!=14; when w==14 go LEN_HI without emitting.
REQ-025 If marker word was emitted at w=14 or 15, ZERO SHALL fill to w=15 and continue in the next block through w=13 (extra block).
REQ-026 LEN_HI at w=14: emit length[63:32]; LEN_LO at w=15: emit length[31:0] with out_msg_end=1; then clear counter, w=0, go DATA.
REQ-027 out_msg_end SHALL be 0 on all other words; a message SHALL contain at least 1 byte.
REQ-028 active deasserting mid-message SHALL freeze state, counter and any pending output word; resume unchanged on reassert.

Reset
REQ-029 On wb_rst_ni=0, asynchronously: state=DATA, w=0, counter=0, out_valid=0, out_data=0, out_first/out_blk_end/out_msg_end=0; in_ready=0 while reset asserted.
REQ-030 Reset mid-message SHALL discard the partial message; first word after release is w=0 of a new message.

Verification
REQ-031 "abc": in_data=0x61626300, in_last=1, in_bytes=3 -> 16 words: 0x61626380, 14x 0x00000000, 0x00000018; out_msg_end only on last.
REQ-032 55 bytes (14 words, last in_bytes=3) -> one block, word13 low byte 0x80, word14=0, word15=0x000001B8.
REQ-033 56 bytes (14 words, last in_bytes=0) -> block1 words14=0x80000000, 15=0 with out_blk_end=1, out_msg_end=0; block2 words0-13=0, 14=0, 15=0x000001C0, out_msg_end=1.
REQ-034 Random out_ready stalls on REQ-031 stream -> identical word sequence, no word dropped or duplicated, out_data stable during stall.
REQ-035 Assert wb_rst_ni=0 after 5 words of a message -> outputs zero immediately; new "abc" message afterwards yields REQ-031 result.
REQ-036 Deassert active for 10 cycles mid-padding -> no transfers during gap; final sequence matches unpaused run.
